// File: rtl/tone_bank.sv
`default_nettype none
// ============================================================================
// Module      : tone_bank
// Description : Bank of NCH square-wave tone generators with per-channel
//               period and optional note duration (TONE_DUR_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tone_bank #(
    parameter int NCH  = 8,
    parameter int DW   = 20,
    parameter int DURW = 16,
    parameter int TICK = 12000
) (
    input  logic                                     clk,
    input  logic                                     rstn,
    input  logic                                     wr,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] addr,
    input  logic [DW-1:0]                            div,
    input  logic [DURW-1:0]                          dur,
    output logic [NCH-1:0]                           ch,
    output logic [NCH-1:0]                           busy,
    output logic [NCH-1:0]                           done
);

    localparam int c_aw = (NCH > 1) ? $clog2(NCH) : 1;

`ifdef TONE_DUR_EN
    localparam int c_pw = (TICK > 1) ? $clog2(TICK) : 1;

    logic [c_pw-1:0] r_pre;
    logic            w_tick;

    // Shared duration prescaler; writes never disturb its phase.
    assign w_tick = (r_pre == c_pw'(TICK - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pre <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + c_pw'(1);
        end
    end
`else
    localparam int c_unused_cfg = TICK + DURW;
    logic          w_unused_dur;

    assign w_unused_dur = ^dur;
`endif

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [DW-1:0] r_per;
        logic [DW-1:0] r_cnt;
        logic          r_act;
        logic          r_ch;
        logic          r_done;
        logic          w_sel;
        logic          w_wrap;
        logic          w_expire;

        // Out-of-range addresses never match any channel index.
        assign w_sel  = wr && (addr == c_aw'(i));
        assign w_wrap = (r_cnt == (r_per - DW'(1)));

`ifdef TONE_DUR_EN
        logic [DURW-1:0] r_rem;

        assign w_expire = w_tick && r_act && (r_rem == DURW'(1));

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_rem <= '0;
            end else if (w_sel) begin
                r_rem <= dur;
            end else if (w_tick && r_act && (r_rem != '0)) begin
                r_rem <= r_rem - DURW'(1);
            end
        end
`else
        assign w_expire = 1'b0;
`endif

        // A write on the expiry edge takes priority and suppresses done.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_per  <= '0;
                r_cnt  <= '0;
                r_act  <= 1'b0;
                r_ch   <= 1'b0;
                r_done <= 1'b0;
            end else begin
                r_ch   <= r_act && (r_cnt < (r_per >> 1));
                r_done <= 1'b0;
                if (w_sel) begin
                    r_per <= div;
                    r_cnt <= '0;
                    r_act <= (div >= DW'(2));
                end else if (w_expire) begin
                    r_act  <= 1'b0;
                    r_cnt  <= '0;
                    r_done <= 1'b1;
                end else if (r_act) begin
                    r_cnt <= w_wrap ? '0 : (r_cnt + DW'(1));
                end else begin
                    r_cnt <= '0;
                end
            end
        end

        assign ch[i]   = r_ch;
        assign busy[i] = r_act;
        assign done[i] = r_done;
    end

endmodule
`default_nettype wire

// File: tb/tb_tone_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_tone_bank
// Description : Directed, table-driven bench for tone_bank (NCH=6, DW=8,
//               DURW=4, TICK=4); duration cases follow TONE_DUR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tone_bank;

    localparam int NCH  = 6;
    localparam int DW   = 8;
    localparam int DURW = 4;
    localparam int TICK = 4;

    logic           clk  = 1'b0;
    logic           rstn = 1'b0;
    logic           wr   = 1'b0;
    logic [2:0]     addr = '0;
    logic [DW-1:0]  div  = '0;
    logic [DURW-1:0] dur = '0;
    logic [NCH-1:0] ch;
    logic [NCH-1:0] busy;
    logic [NCH-1:0] done;

    int checks = 0;
    int errors = 0;
    int edges;

    typedef struct {
        logic           w;
        logic [2:0]     a;
        logic [DW-1:0]  d;
        logic [DURW-1:0] u;
        logic [NCH-1:0] ch;
        logic [NCH-1:0] busy;
        logic [NCH-1:0] done;
    } vec_t;

    vec_t vecs[$];

    tone_bank #(
        .NCH  (NCH),
        .DW   (DW),
        .DURW (DURW),
        .TICK (TICK)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .wr   (wr),
        .addr (addr),
        .div  (div),
        .dur  (dur),
        .ch   (ch),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    // Edge count since reset release; tick edges are the multiples of TICK.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) edges <= 0;
        else       edges <= edges + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [2:0] a, input logic [DW-1:0] d,
                         input logic [DURW-1:0] u);
        wr = w; addr = a; div = d; dur = u;
    endtask

    task automatic add(input logic w, input logic [2:0] a, input logic [DW-1:0] d,
                       input logic [DURW-1:0] u, input logic [NCH-1:0] c,
                       input logic [NCH-1:0] b, input logic [NCH-1:0] dn);
        vec_t v;
        v.w = w; v.a = a; v.d = d; v.u = u; v.ch = c; v.busy = b; v.done = dn;
        vecs.push_back(v);
    endtask

    // Wait (bounded) until the coming edge has edge index == r modulo TICK.
    task automatic align(input int r);
        int n = 0;
        while ((((edges + 1) % TICK) != r) && (n < 2 * TICK)) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int e0, exp_drop, hi;
        logic dropped, early, bad;

        // wr  addr div dur | ch     busy   done  (outputs after the edge)
        add(1, 2, 4, 0, 6'h00, 6'h04, 6'h00);
        add(0, 0, 0, 0, 6'h04, 6'h04, 6'h00);
        add(0, 0, 0, 0, 6'h04, 6'h04, 6'h00);
        add(0, 0, 0, 0, 6'h00, 6'h04, 6'h00);
        add(0, 0, 0, 0, 6'h00, 6'h04, 6'h00);
        add(0, 0, 0, 0, 6'h04, 6'h04, 6'h00);
        add(0, 0, 0, 0, 6'h04, 6'h04, 6'h00);
        add(0, 0, 0, 0, 6'h00, 6'h04, 6'h00);
        add(1, 2, 0, 0, 6'h00, 6'h00, 6'h00);
        add(0, 0, 0, 0, 6'h00, 6'h00, 6'h00);
        add(1, 0, 5, 0, 6'h00, 6'h01, 6'h00);
        add(0, 0, 0, 0, 6'h01, 6'h01, 6'h00);
        add(0, 0, 0, 0, 6'h01, 6'h01, 6'h00);
        add(0, 0, 0, 0, 6'h00, 6'h01, 6'h00);
        add(0, 0, 0, 0, 6'h00, 6'h01, 6'h00);
        add(0, 0, 0, 0, 6'h00, 6'h01, 6'h00);
        add(0, 0, 0, 0, 6'h01, 6'h01, 6'h00);
        add(1, 0, 1, 0, 6'h01, 6'h00, 6'h00);
        add(0, 0, 0, 0, 6'h00, 6'h00, 6'h00);
        add(1, 6, 4, 0, 6'h00, 6'h00, 6'h00);
        add(1, 7, 2, 0, 6'h00, 6'h00, 6'h00);
        add(1, 5, 2, 0, 6'h00, 6'h20, 6'h00);
        add(0, 0, 0, 0, 6'h20, 6'h20, 6'h00);
        add(0, 0, 0, 0, 6'h00, 6'h20, 6'h00);
        add(0, 0, 0, 0, 6'h20, 6'h20, 6'h00);
        add(1, 5, 3, 0, 6'h00, 6'h20, 6'h00);
        add(0, 0, 0, 0, 6'h20, 6'h20, 6'h00);
        add(0, 0, 0, 0, 6'h00, 6'h20, 6'h00);
        add(0, 0, 0, 0, 6'h00, 6'h20, 6'h00);
        add(0, 0, 0, 0, 6'h20, 6'h20, 6'h00);
        add(1, 5, 0, 0, 6'h00, 6'h00, 6'h00);

        // Power-on reset
        repeat (2) @(negedge clk);
        chk("reset ch", ch, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        rstn = 1'b1;

        // Asynchronous reset in the middle of a running tone
        drive(1, 0, 4, 0);
        @(negedge clk);
        drive(0, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk("pre-reset busy", busy, 6'h01);
        #2 rstn = 1'b0;
        #1;
        chk("async reset ch", ch, 0);
        chk("async reset busy", busy, 0);
        chk("async reset done", done, 0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        chk("post-reset ch", ch, 0);
        chk("post-reset busy", busy, 0);

        // Table-driven tone vectors
        foreach (vecs[k]) begin
            drive(vecs[k].w, vecs[k].a, vecs[k].d, vecs[k].u);
            @(negedge clk);
            chk($sformatf("vec%0d ch", k), ch, vecs[k].ch);
            chk($sformatf("vec%0d busy", k), busy, vecs[k].busy);
            chk($sformatf("vec%0d done", k), done, vecs[k].done);
        end
        drive(0, 0, 0, 0);
        @(negedge clk);

`ifdef TONE_DUR_EN
        // Note of 3 ticks: expiry on the 3rd tick edge after the write
        drive(1, 1, 4, 3);
        @(negedge clk);
        drive(0, 0, 0, 0);
        e0 = edges;
        chk("dur busy set", busy[1], 1);
        exp_drop = (e0 / TICK + 3) * TICK;
        dropped = 0;
        early = 0;
        for (int i = 0; i < 20 && !dropped; i++) begin
            @(negedge clk);
            if (!busy[1]) dropped = 1;
            else if (done[1]) early = 1;
        end
        chk("dur expired", dropped, 1);
        chk("dur drop edge", edges, exp_drop);
        chk("dur length 9..12", (edges - e0 >= 9) && (edges - e0 <= 12), 1);
        chk("dur done pulse", done, 6'h02);
        chk("dur no early done", early, 0);
        @(negedge clk);
        chk("dur done cleared", done, 0);
        chk("dur ch off", ch[1], 0);

        // Two channels expiring on the same tick
        align(1);
        drive(1, 3, 4, 1);
        @(negedge clk);
        drive(1, 4, 6, 1);
        @(negedge clk);
        drive(0, 0, 0, 0);
        @(negedge clk);
        chk("multi busy", busy, 6'h18);
        chk("multi no done yet", done, 0);
        @(negedge clk);
        chk("multi done", done, 6'h18);
        chk("multi busy cleared", busy, 0);
        @(negedge clk);
        chk("multi done pulse", done, 0);

        // Rewrite on the expiry edge wins: no done, tone restarts
        align(0);
        drive(1, 1, 4, 1);
        @(negedge clk);
        drive(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("retrig busy before", busy[1], 1);
        drive(1, 1, 4, 2);
        @(negedge clk);
        drive(0, 0, 0, 0);
        chk("retrig busy", busy[1], 1);
        chk("retrig no done", done, 0);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ch[1] !== (i < 2)) bad = 1;
            if (done !== 0) bad = 1;
        end
        chk("retrig restart phase", bad, 0);
`else
        // Duration ignored: note plays until rewritten
        drive(1, 3, 6, 2);
        @(negedge clk);
        drive(0, 0, 0, 0);
        bad = 0;
        hi = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (busy !== 6'h08 || done !== 0) bad = 1;
            if (ch[3]) hi++;
        end
        chk("nodur busy held no done", bad, 0);
        chk("nodur high cycles", hi, 60);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
